stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control/sequencing block for the ms/sec/min/hour stopwatch counter datapath. Converts raw push-buttons into run, clear and load commands, and generates the 1 kHz count-enable tick. Registers the preset values that the counter loads, and drives the display outputs. Sits between the board I/O (buttons, switches) and the counter; the counter advances one ms per tick_o while run_o=1.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ (integer, must be ≥2)
DIV_W, 17, prescaler width; must satisfy 2**DIV_W ≥ DIV

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous reset, active-low
btn_start_i  in  1  start/stop button, asynchronous level
btn_lap_i  in  1  lap button, asynchronous level
btn_clr_i  in  1  clear button, asynchronous level
btn_load_i  in  1  load-preset button, asynchronous level
hour_set_i  in  5  preset hours (0–23 valid)
min_set_i  in  6  preset minutes (0–59 valid)
sec_set_i  in  6  preset seconds (0–59 valid)
hour_i / min_i / sec_i / ms_i  in  5/6/6/10  live counter values
run_o  out  1  counter enable level
tick_o  out  1  one-cycle ms advance pulse
clear_o  out  1  one-cycle pulse; counter zeroes all fields
load_o  out  1  one-cycle pulse; counter loads *_ld_o, with ms set to 0
hour_ld_o / min_ld_o / sec_ld_o  out  5/6/6  registered preset values
err_o  out  1  one-cycle pulse on rejected load
state_o  out  2  FSM state code
disp_hour_o / disp_min_o / disp_sec_o / disp_ms_o  out  5/6/6/10  display values

Behaviour:
- Reset (reset_i=0, async): FSM=IDLE; prescaler=0; every output 0.
- Each button passes through a 2-flop synchronizer and a rising-edge detector. One press gives one event, 3 cycles after the input edge. A held button gives no repeat events.
- States, each with its code:
  - IDLE=0: stopped at zero or preset.
  - RUN=1: counting.
  - PAUSE=2: stopped with a held value.
  - LAP=3: counting with the display frozen.
- Event priority within one cycle: clr > load > start > lap. Only the highest-priority valid event acts; the others are dropped.
- clr, from any state: clear_o=1 for one cycle, next state IDLE, prescaler forced to 0.
- load, valid only in IDLE or PAUSE:
  - If hour_set_i≤23, min_set_i≤59 and sec_set_i≤59: capture them into *_ld_o and pulse load_o. The state does not change.
  - Otherwise pulse err_o and leave *_ld_o unchanged.
  - In RUN or LAP the load event is ignored, with no err_o.
- start transitions: IDLE→RUN, RUN→PAUSE, PAUSE→RUN, LAP→PAUSE. On LAP→PAUSE the display is released to live values.
- lap transitions: RUN→LAP, which snapshots hour_i/min_i/sec_i/ms_i in the same cycle; LAP→RUN releases the display. lap in IDLE or PAUSE is ignored.
- run_o=1 exactly in RUN and LAP, registered from the state.
- Prescaler:
  - Counts 0..DIV-1 only while run_o=1 and holds its value while paused.
  - tick_o=1 in the cycle where prescaler==DIV-1 and run_o=1; the prescaler then wraps to 0.
  - The first tick after IDLE→RUN arrives DIV cycles after run_o rises.
- Display outputs: registered, 1-cycle latency from the live inputs. In LAP they hold the snapshot.
- Wrap-around of hours/min/sec is the counter's job; this block never inspects carries.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: LAP state and the snapshot registers exist, as described above.
- Undefined:
  - btn_lap_i is unused and LAP is unreachable; state_o never equals 3.
  - Display outputs are always the live values delayed by 1 cycle.
  - All other behaviour is identical.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding constants (IDLE/RUN/PAUSE/LAP);
  - the field widths (HOUR_W=5, MIN_W=6, SEC_W=6, MS_W=10);
  - the limits HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, MS_MAX=999.
- One sub-module, btn_edge: 2-flop synchronizer plus rising-edge pulse, instantiated four times.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10).
- Reset mid-RUN: assert reset_i=0 at prescaler=5 → all outputs 0 immediately, state_o=0, and after release the first tick comes only after a new start and 10 cycles.
- start pulse → run_o=1 at +4 cycles. tick_o pulses every 10 cycles; 35 ticks are counted in 350 cycles. A second start → state_o=2, run_o=0, prescaler frozen. A third start → the next tick arrives after the remaining count, not after a full 10.
- load in PAUSE with 12/34/56 → load_o pulse, hour_ld_o=12, min_ld_o=34, sec_ld_o=56. load with min_set_i=60 → err_o pulse, *_ld_o unchanged. load in RUN → no pulse at all.
- clr and start edges arriving in the same cycle while in RUN → clear_o pulse, state IDLE, run_o=0, no PAUSE.
- STOPWATCH_LAP_EN: lap at live value 0:00:03.250 → display holds 3/250 while ms_i keeps changing. A second lap → the display tracks live values after 1 cycle. start from LAP → PAUSE with a live display.
- Held button: btn_start_i high for 1000 cycles → exactly one state transition.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch control slice.
//   state_e        FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   *_W            field widths of the hour/min/sec/ms counter datapath
//   *_MAX          largest legal value of each field
//   preset_ok()    true when a preset triple is a legal time of day
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_e;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MS_W   = 10;

   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MS_MAX   = 999;

   function automatic logic preset_ok(input logic [HOUR_W-1:0] hour,
                                      input logic [MIN_W-1:0]  min,
                                      input logic [SEC_W-1:0]  sec);
      return (hour <= HOUR_W'(HOUR_MAX)) &&
             (min  <= MIN_W'(MIN_MAX))   &&
             (sec  <= SEC_W'(SEC_MAX));
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: brings one asynchronous push-button into the clk_i domain and
// turns each rising edge into a single-cycle pulse.
//   clk_i    system clock
//   reset_i  asynchronous reset, active-low
//   btn_i    raw button level (asynchronous)
//   pulse_o  one-cycle pulse, registered, 3 cycles after the input edge;
//            a held button produces no further pulses
module btn_edge (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_o <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old
         // value of its neighbour, which is what forms the shift chain.
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_o <= sync2_q & ~prev_q;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control/sequencing for the ms/sec/min/hour stopwatch.
// Turns buttons into run/clear/load commands, generates the ms tick,
// registers the preset values and drives the display.
//   clk_i, reset_i                  clock, asynchronous active-low reset
//   btn_start/lap/clr/load_i        raw button levels
//   hour/min/sec_set_i              preset values for load
//   hour/min/sec/ms_i               live counter values
//   run_o, tick_o                   counter enable level, ms advance pulse
//   clear_o, load_o, err_o          one-cycle command / rejection pulses
//   hour/min/sec_ld_o               registered preset values
//   state_o                         FSM state code
//   disp_hour/min/sec/ms_o          display values (1-cycle latency)
// Build option STOPWATCH_LAP_EN: when defined, the LAP state and the frozen
// lap display exist; otherwise btn_lap_i is unused and LAP is unreachable.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1000,
   parameter int unsigned DIV_W   = 17
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              btn_start_i,
   input  logic              btn_lap_i,
   input  logic              btn_clr_i,
   input  logic              btn_load_i,
   input  logic [HOUR_W-1:0] hour_set_i,
   input  logic [MIN_W-1:0]  min_set_i,
   input  logic [SEC_W-1:0]  sec_set_i,
   input  logic [HOUR_W-1:0] hour_i,
   input  logic [MIN_W-1:0]  min_i,
   input  logic [SEC_W-1:0]  sec_i,
   input  logic [MS_W-1:0]   ms_i,
   output logic              run_o,
   output logic              tick_o,
   output logic              clear_o,
   output logic              load_o,
   output logic [HOUR_W-1:0] hour_ld_o,
   output logic [MIN_W-1:0]  min_ld_o,
   output logic [SEC_W-1:0]  sec_ld_o,
   output logic              err_o,
   output logic [1:0]        state_o,
   output logic [HOUR_W-1:0] disp_hour_o,
   output logic [MIN_W-1:0]  disp_min_o,
   output logic [SEC_W-1:0]  disp_sec_o,
   output logic [MS_W-1:0]   disp_ms_o
);

   localparam int unsigned      DIV        = CLK_HZ / TICK_HZ;
   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

   logic start_ev, clr_ev, load_ev, lap_ev;

   btn_edge u_start (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_start_i), .pulse_o(start_ev));
   btn_edge u_clr   (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_clr_i),   .pulse_o(clr_ev));
   btn_edge u_load  (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_load_i),  .pulse_o(load_ev));
`ifdef STOPWATCH_LAP_EN
   btn_edge u_lap   (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_lap_i),   .pulse_o(lap_ev));
`else
   logic lap_unused;
   assign lap_unused = btn_lap_i;
   assign lap_ev     = 1'b0;
`endif

   state_e           state_q, next_state;
   logic             do_clear, do_load, do_err;
   logic             run_q;
   logic [DIV_W-1:0] presc_q;

   // Events are resolved strictly by priority clr > load > start > lap;
   // an event that is not valid in the current state falls through.
   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      next_state = state_q;
      do_clear   = 1'b0;
      do_load    = 1'b0;
      do_err     = 1'b0;
      if (clr_ev) begin
         do_clear   = 1'b1;
         next_state = ST_IDLE;
      end else if (load_ev && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
         if (preset_ok(hour_set_i, min_set_i, sec_set_i)) do_load = 1'b1;
         else                                             do_err  = 1'b1;
      end else if (start_ev) begin
         next_state = (state_q == ST_RUN || state_q == ST_LAP) ? ST_PAUSE : ST_RUN;
      end else if (lap_ev && state_q == ST_RUN) begin
         next_state = ST_LAP;
      end else if (lap_ev && state_q == ST_LAP) begin
         next_state = ST_RUN;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= ST_IDLE;
         run_q     <= 1'b0;
         clear_o   <= 1'b0;
         load_o    <= 1'b0;
         err_o     <= 1'b0;
         hour_ld_o <= '0;
         min_ld_o  <= '0;
         sec_ld_o  <= '0;
         presc_q   <= '0;
      end else begin
         state_q <= next_state;
         run_q   <= (next_state == ST_RUN) || (next_state == ST_LAP);
         clear_o <= do_clear;
         load_o  <= do_load;
         err_o   <= do_err;
         if (do_load) begin
            hour_ld_o <= hour_set_i;
            min_ld_o  <= min_set_i;
            sec_ld_o  <= sec_set_i;
         end
         // The prescaler only advances while the counter is enabled, so a
         // pause keeps the partial ms and resume continues from it.
         if (do_clear)   presc_q <= '0;
         else if (run_q) presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      end
   end

   assign run_o   = run_q;
   assign tick_o  = run_q && (presc_q == PRESC_LAST);
   assign state_o = state_q;

   // While staying in LAP the display registers hold the values captured on
   // entry, so they double as the lap snapshot.
   logic freeze;
`ifdef STOPWATCH_LAP_EN
   assign freeze = (state_q == ST_LAP) && (next_state == ST_LAP);
`else
   assign freeze = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         disp_hour_o <= '0;
         disp_min_o  <= '0;
         disp_sec_o  <= '0;
         disp_ms_o   <= '0;
      end else if (!freeze) begin
         disp_hour_o <= hour_i;
         disp_min_o  <= min_i;
         disp_sec_o  <= sec_i;
         disp_ms_o   <= ms_i;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl with DIV=10.
// A behavioural model tracks accumulated run time, the button event delay
// and the state rules; every cycle all outputs are compared with it.
module tb_stopwatch_ctrl;

   localparam int DIV = 10;
   localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       btn_start_i, btn_lap_i, btn_clr_i, btn_load_i;
   logic [4:0] hour_set_i, hour_i, hour_ld_o, disp_hour_o;
   logic [5:0] min_set_i, sec_set_i, min_i, sec_i, min_ld_o, sec_ld_o, disp_min_o, disp_sec_o;
   logic [9:0] ms_i, disp_ms_o;
   logic       run_o, tick_o, clear_o, load_o, err_o;
   logic [1:0] state_o;

   stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIV_W(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .btn_start_i(btn_start_i), .btn_lap_i(btn_lap_i), .btn_clr_i(btn_clr_i), .btn_load_i(btn_load_i),
      .hour_set_i(hour_set_i), .min_set_i(min_set_i), .sec_set_i(sec_set_i),
      .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i), .ms_i(ms_i),
      .run_o(run_o), .tick_o(tick_o), .clear_o(clear_o), .load_o(load_o),
      .hour_ld_o(hour_ld_o), .min_ld_o(min_ld_o), .sec_ld_o(sec_ld_o),
      .err_o(err_o), .state_o(state_o),
      .disp_hour_o(disp_hour_o), .disp_min_o(disp_min_o), .disp_sec_o(disp_sec_o), .disp_ms_o(disp_ms_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_state, m_elapsed, m_hld, m_mld, m_sld, m_dh, m_dm, m_ds, m_dms;
   bit m_run, m_clear, m_load, m_err;
   // sample history of each button: bit k = level seen k+1 edges ago
   bit [3:0] h_start, h_clr, h_load, h_lap;

   always @(posedge clk_i or negedge reset_i) begin
      bit e_s, e_c, e_l, e_p;
      int nxt;
      if (!reset_i) begin
         m_state = IDLE; m_elapsed = 0; m_run = 0;
         m_clear = 0; m_load = 0; m_err = 0;
         m_hld = 0; m_mld = 0; m_sld = 0;
         m_dh = 0; m_dm = 0; m_ds = 0; m_dms = 0;
         h_start = 0; h_clr = 0; h_load = 0; h_lap = 0;
      end else begin
         // a press acts 3 edges after the edge that first sees it high
         e_s = h_start[2] && !h_start[3];
         e_c = h_clr[2]   && !h_clr[3];
         e_l = h_load[2]  && !h_load[3];
         e_p = h_lap[2]   && !h_lap[3] && LAP_EN;
         h_start = {h_start[2:0], btn_start_i};
         h_clr   = {h_clr[2:0],   btn_clr_i};
         h_load  = {h_load[2:0],  btn_load_i};
         h_lap   = {h_lap[2:0],   btn_lap_i};

         if (m_run) m_elapsed++;
         m_clear = 0; m_load = 0; m_err = 0;
         nxt = m_state;
         if (e_c) begin
            m_clear = 1; nxt = IDLE; m_elapsed = 0;
         end else if (e_l && (m_state == IDLE || m_state == PAUSE)) begin
            if (hour_set_i <= 23 && min_set_i <= 59 && sec_set_i <= 59) begin
               m_load = 1; m_hld = hour_set_i; m_mld = min_set_i; m_sld = sec_set_i;
            end else m_err = 1;
         end else if (e_s) begin
            nxt = (m_state == RUN || m_state == LAP) ? PAUSE : RUN;
         end else if (e_p && m_state == RUN) nxt = LAP;
         else if (e_p && m_state == LAP) nxt = RUN;

         if (!(m_state == LAP && nxt == LAP)) begin
            m_dh = hour_i; m_dm = min_i; m_ds = sec_i; m_dms = ms_i;
         end
         m_state = nxt;
         m_run   = (m_state == RUN || m_state == LAP);
      end
   end

   bit cmp_en = 0;
   always @(negedge clk_i) begin
      if (cmp_en && reset_i) begin
         check("state", state_o, m_state);
         check("run", run_o, m_run);
         check("tick", tick_o, m_run && (m_elapsed % DIV == DIV - 1));
         check("clear", clear_o, m_clear);
         check("load", load_o, m_load);
         check("err", err_o, m_err);
         check("hour_ld", hour_ld_o, m_hld);
         check("min_ld", min_ld_o, m_mld);
         check("sec_ld", sec_ld_o, m_sld);
         check("disp_hour", disp_hour_o, m_dh);
         check("disp_min", disp_min_o, m_dm);
         check("disp_sec", disp_sec_o, m_ds);
         check("disp_ms", disp_ms_o, m_dms);
      end
   end

   // live counter values change every cycle
   initial begin
      hour_i = 0; min_i = 0; sec_i = 0; ms_i = 0;
      forever begin
         @(negedge clk_i);
         hour_i = 5'($urandom_range(0, 23));
         min_i  = 6'($urandom_range(0, 59));
         sec_i  = 6'($urandom_range(0, 59));
         ms_i   = 10'($urandom_range(0, 999));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_start_i = v;
         1: btn_clr_i   = v;
         2: btn_load_i  = v;
         default: btn_lap_i = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      cyc(1);
      set_btn(b, 1'b0);
   endtask

   task automatic watch(input int n, output int loads, output int errs, output int clrs);
      loads = 0; errs = 0; clrs = 0;
      repeat (n) begin
         @(negedge clk_i);
         loads += int'(load_o); errs += int'(err_o); clrs += int'(clear_o);
      end
   endtask

   localparam int B_START = 0, B_CLR = 1, B_LOAD = 2, B_LAP = 3;

   initial begin
      int k, ticks, loads, errs, clrs, changes, prev;
      logic [9:0] snap;
      reset_i = 1'b0;
      btn_start_i = 0; btn_lap_i = 0; btn_clr_i = 0; btn_load_i = 0;
      hour_set_i = 0; min_set_i = 0; sec_set_i = 0;
      cyc(3);
      check("rst_state", state_o, IDLE);
      check("rst_run", run_o, 0);
      check("rst_ld", {hour_ld_o, min_ld_o, sec_ld_o}, 0);
      reset_i = 1'b1;
      cmp_en  = 1;

      // start latency and tick rate
      set_btn(B_START, 1'b1);
      for (k = 1; k <= 20; k++) begin
         @(negedge clk_i);
         if (k == 1) set_btn(B_START, 1'b0);
         if (run_o) break;
      end
      check("start_latency", k, 4);
      ticks = 0;
      repeat (350) begin @(negedge clk_i); ticks += int'(tick_o); end
      check("tick_count_350", ticks, 35);

      // pause and resume mid-count
      cyc(3);
      press(B_START); cyc(6);
      check("pause_state", state_o, PAUSE);
      check("pause_run", run_o, 0);
      cyc(7);
      press(B_START); cyc(30);

      // asynchronous reset mid-run at prescaler 5
      for (k = 0; k < 30; k++) begin @(negedge clk_i); if (tick_o) break; end
      check("tick_seen", k < 30, 1);
      cyc(6);
      #2 reset_i = 1'b0;
      #1;
      check("arst_state", state_o, IDLE);
      check("arst_outs", {run_o, tick_o, clear_o, load_o, err_o}, 0);
      check("arst_disp", {disp_hour_o, disp_min_o, disp_sec_o, disp_ms_o}, 0);
      cyc(2);
      reset_i = 1'b1;
      ticks = 0;
      repeat (20) begin @(negedge clk_i); ticks += int'(tick_o); end
      check("no_tick_after_rst", ticks, 0);
      press(B_START); cyc(25);

      // loads: valid in PAUSE, invalid minutes, ignored in RUN
      press(B_START); cyc(6);
      hour_set_i = 12; min_set_i = 34; sec_set_i = 56;
      press(B_LOAD); watch(8, loads, errs, clrs);
      check("load_pulse", loads, 1);
      check("load_vals", {hour_ld_o, min_ld_o, sec_ld_o}, {5'd12, 6'd34, 6'd56});
      min_set_i = 60;
      press(B_LOAD); watch(8, loads, errs, clrs);
      check("bad_load_err", errs, 1);
      check("bad_load_keep", min_ld_o, 34);
      press(B_START); cyc(6);
      hour_set_i = 1; min_set_i = 2; sec_set_i = 3;
      press(B_LOAD); watch(8, loads, errs, clrs);
      check("run_load_ignored", loads + errs, 0);

      // clr and start together while running
      btn_clr_i = 1; btn_start_i = 1;
      cyc(1);
      btn_clr_i = 0; btn_start_i = 0;
      watch(8, loads, errs, clrs);
      check("clr_pulse", clrs, 1);
      check("clr_state", state_o, IDLE);

      // held start button: one transition only
      changes = 0; prev = state_o;
      btn_start_i = 1;
      repeat (1000) begin
         @(negedge clk_i);
         if (state_o != prev) changes++;
         prev = state_o;
      end
      btn_start_i = 0;
      check("held_transitions", changes, 1);
      press(B_CLR); cyc(6);

`ifdef STOPWATCH_LAP_EN
      // lap freezes the display, second lap releases, start from LAP pauses
      press(B_START); cyc(20);
      press(B_LAP);
      for (k = 0; k < 10; k++) begin @(negedge clk_i); if (state_o == LAP) break; end
      check("lap_enter", state_o, LAP);
      snap = disp_ms_o;
      cyc(10);
      check("lap_frozen", disp_ms_o, snap);
      press(B_LAP); cyc(6);
      check("lap_release", state_o, RUN);
      press(B_LAP); cyc(6);
      press(B_START); cyc(6);
      check("lap_to_pause", state_o, PAUSE);
      press(B_CLR); cyc(6);
`else
      // lap button has no effect without the lap feature
      press(B_START); cyc(10);
      press(B_LAP); cyc(10);
      check("lap_disabled", state_o, RUN);
      press(B_CLR); cyc(6);
`endif

      // randomized button traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_i);
         if ($urandom_range(0, 11) == 0) btn_start_i = ~btn_start_i;
         if ($urandom_range(0, 13) == 0) btn_lap_i   = ~btn_lap_i;
         if ($urandom_range(0, 15) == 0) btn_load_i  = ~btn_load_i;
         if ($urandom_range(0, 63) == 0) btn_clr_i   = ~btn_clr_i;
         if ($urandom_range(0, 7) == 0) begin
            hour_set_i = 5'($urandom_range(0, 25));
            min_set_i  = 6'($urandom_range(0, 61));
            sec_set_i  = 6'($urandom_range(0, 61));
         end
      end
      btn_start_i = 0; btn_lap_i = 0; btn_load_i = 0; btn_clr_i = 0;
      cyc(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
